// File: rtl/cic_decim_mc.sv
// Time-multiplexed multi-channel CIC decimator: one shared integrator/comb datapath,
// runtime decimation latched on frame/period boundaries, output shift with saturation.
module cic_decim_mc #(
   parameter int NumCh         = 4,
   parameter int N             = 4,
   parameter int M             = 1,
   parameter int InDataWidth   = 14,
   parameter int AccWidth      = 42,
   parameter int OutDataWidth  = 16,
   parameter int DecimCntWidth = 7,
   parameter int ShiftWidth    = 6,
   localparam int ChWidth      = (NumCh > 1) ? $clog2(NumCh) : 1
) (
   input  logic                     Clk_i,
   input  logic                     Rst_i,
   input  logic [DecimCntWidth-1:0] DecimFactor_i,
   input  logic [ShiftWidth-1:0]    Shift_i,
   input  logic [InDataWidth-1:0]   Data_i,
   input  logic                     DataNd_i,
   output logic [OutDataWidth-1:0]  Data_o,
   output logic                     DataValid_o,
   output logic [ChWidth-1:0]       Channel_o,
   output logic                     Overflow_o
);

   // DataNd_i qualifies Data_i in its cycle; there is no backpressure, so every
   // asserted DataNd_i is consumed. DataValid_o is a one-cycle pulse per output.

   logic [ChWidth-1:0]       ch;
   logic [DecimCntWidth-1:0] dc;
   logic [DecimCntWidth-1:0] rlat;
   logic [DecimCntWidth-1:0] r_cur;
   logic [DecimCntWidth-1:0] r_eff;
   logic                     relatch;
   logic                     ch_wrap;
   logic                     period_end;
   logic                     fire;
   logic                     fits;

   logic signed [AccWidth-1:0] integ [NumCh][N];
   logic signed [AccWidth-1:0] dly   [NumCh][N][M];
   logic signed [AccWidth-1:0] isum  [N];
   logic signed [AccWidth-1:0] x     [N+1];
   logic signed [AccWidth-1:0] y;
   logic [AccWidth-OutDataWidth:0] y_top;
   logic [OutDataWidth-1:0]    sat_val;

   always_comb begin
      relatch    = DataNd_i && (ch == '0) && (dc == '0);
      // A newly latched ratio must already govern the sample that latches it.
      r_cur      = relatch ? DecimFactor_i : rlat;
      r_eff      = (r_cur <= DecimCntWidth'(1)) ? DecimCntWidth'(1) : r_cur;
      ch_wrap    = (ch == ChWidth'(NumCh - 1));
      period_end = (dc == r_eff - DecimCntWidth'(1));
      fire       = DataNd_i && period_end;

      isum[0] = integ[ch][0] + {{(AccWidth-InDataWidth){Data_i[InDataWidth-1]}}, Data_i};
      for (int k = 1; k < N; k++) begin
         isum[k] = integ[ch][k] + isum[k-1];
      end

      x[0] = isum[N-1];
      for (int k = 0; k < N; k++) begin
         x[k+1] = x[k] - dly[ch][k][M-1];
      end

      y       = x[N] >>> Shift_i;
      y_top   = y[AccWidth-1:OutDataWidth-1];
      fits    = (&y_top) || !(|y_top);
      sat_val = fits ? y[OutDataWidth-1:0]
                     : {y[AccWidth-1], {(OutDataWidth-1){~y[AccWidth-1]}}};
   end

   always_ff @(posedge Clk_i) begin
      if (Rst_i) begin
         ch          <= '0;
         dc          <= '0;
         rlat        <= DecimFactor_i;
         Data_o      <= '0;
         DataValid_o <= 1'b0;
         Channel_o   <= '0;
         Overflow_o  <= 1'b0;
         for (int c = 0; c < NumCh; c++) begin
            for (int k = 0; k < N; k++) begin
               integ[c][k] <= '0;
               for (int j = 0; j < M; j++) begin
                  dly[c][k][j] <= '0;
               end
            end
         end
      end else begin
         DataValid_o <= fire;
         Overflow_o  <= fire && !fits;
         if (DataNd_i) begin
            if (relatch) begin
               rlat <= DecimFactor_i;
            end
            ch <= ch_wrap ? '0 : ch + ChWidth'(1);
            if (ch_wrap) begin
               dc <= period_end ? '0 : dc + DecimCntWidth'(1);
            end
            for (int k = 0; k < N; k++) begin
               integ[ch][k] <= isum[k];
            end
            if (period_end) begin
               Data_o    <= sat_val;
               Channel_o <= ch;
               for (int k = 0; k < N; k++) begin
                  dly[ch][k][0] <= x[k];
                  for (int j = M - 1; j > 0; j--) begin
                     dly[ch][k][j] <= dly[ch][k][j-1];
                  end
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_cic_decim_mc.sv
// Bench for cic_decim_mc: DC vector table, impulse and corner sequences, and randomized
// gapped traffic checked against a binomial-difference CIC reference model.
module tb_cic_decim_mc;

   localparam int NCH = 4;
   localparam int NT  = 4;
   localparam int MT  = 1;
   localparam int IW  = 14;
   localparam int ACC = 42;
   localparam int OW  = 16;
   localparam int DW  = 7;
   localparam int SW  = 6;
   localparam int EW  = OW + 3;
   localparam int HL  = NT * MT + 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst = 1'b1;
   logic [DW-1:0] decim = 7'd5;
   logic [SW-1:0] shift = '0;
   logic [IW-1:0] din = '0;
   logic          nd = 1'b0;
   logic [OW-1:0] dout;
   logic          dvalid;
   logic [1:0]    chan;
   logic          ovf;

   logic [IW-1:0] din2 = '0;
   logic          nd2 = 1'b0;
   logic [DW-1:0] decim2 = 7'd4;
   logic [SW-1:0] shift2 = '0;
   logic [OW-1:0] dout2;
   logic          dvalid2;
   logic [0:0]    chan2;
   logic          ovf2;

   cic_decim_mc #(.NumCh(NCH), .N(NT), .M(MT), .InDataWidth(IW), .AccWidth(ACC),
                  .OutDataWidth(OW), .DecimCntWidth(DW), .ShiftWidth(SW)) dut (
      .Clk_i(clk), .Rst_i(rst), .DecimFactor_i(decim), .Shift_i(shift),
      .Data_i(din), .DataNd_i(nd), .Data_o(dout), .DataValid_o(dvalid),
      .Channel_o(chan), .Overflow_o(ovf));

   cic_decim_mc #(.NumCh(1), .N(1), .M(1), .InDataWidth(IW), .AccWidth(ACC),
                  .OutDataWidth(OW), .DecimCntWidth(DW), .ShiftWidth(SW)) dut1 (
      .Clk_i(clk), .Rst_i(rst), .DecimFactor_i(decim2), .Shift_i(shift2),
      .Data_i(din2), .DataNd_i(nd2), .Data_o(dout2), .DataValid_o(dvalid2),
      .Channel_o(chan2), .Overflow_o(ovf2));

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input longint act, input longint expv);
      checks++;
      if (act != expv) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, expv, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [EW-1:0] exp_q[$];
   longint integ_m [NCH][NT];
   longint hist    [NCH][HL];
   int m_ch, m_dc, m_rlat;

   function automatic longint wrap_acc(input longint v);
      return (v <<< (64 - ACC)) >>> (64 - ACC);
   endfunction

   function automatic longint binom(input int n, input int k);
      longint r = 1;
      for (int i = 0; i < k; i++) r = r * (n - i) / (i + 1);
      return r;
   endfunction

   task automatic model_reset();
      m_ch = 0; m_dc = 0; m_rlat = int'(decim);
      for (int c = 0; c < NCH; c++) begin
         for (int k = 0; k < NT; k++) integ_m[c][k] = 0;
         for (int j = 0; j < HL; j++) hist[c][j] = 0;
      end
   endtask

   // Integrators are running sums; the decimated output is the Nth M-spaced
   // difference of the decimated last-integrator sequence (binomial form).
   task automatic model_accept(input longint d);
      int r, c;
      longint prev, xs, yv;
      bit o;
      c = m_ch;
      if (m_ch == 0 && m_dc == 0) m_rlat = int'(decim);
      r = (m_rlat <= 1) ? 1 : m_rlat;
      prev = d;
      for (int k = 0; k < NT; k++) begin
         integ_m[c][k] = wrap_acc(integ_m[c][k] + prev);
         prev = integ_m[c][k];
      end
      if (m_dc == r - 1) begin
         for (int j = HL - 1; j > 0; j--) hist[c][j] = hist[c][j-1];
         hist[c][0] = prev;
         xs = 0;
         for (int j = 0; j <= NT; j++)
            xs += ((j % 2) ? -1 : 1) * binom(NT, j) * hist[c][j*MT];
         xs = wrap_acc(xs);
         yv = xs >>> shift;
         o = 1'b0;
         if (yv > 32767) begin yv = 32767; o = 1'b1; end
         else if (yv < -32768) begin yv = -32768; o = 1'b1; end
         exp_q.push_back({o, 2'(c), OW'(yv)});
      end
      if (m_ch == NCH - 1) begin
         m_ch = 0;
         m_dc = (m_dc == r - 1) ? 0 : m_dc + 1;
      end else begin
         m_ch++;
      end
   endtask

   // ---------------- scoreboard / monitor ----------------
   logic [OW-1:0] held = '0;
   logic [EW-1:0] mon_e;
   longint last_d [NCH];
   bit     last_o [NCH];
   bit     got_first;
   int     first_ch;
   int     n_out;

   always @(negedge clk) begin
      if (rst) begin
         held = '0;
      end else if (dvalid) begin
         if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_valid actual=1 expected=0 ch=%0d at %0t", chan, $time);
         end else begin
            mon_e = exp_q.pop_front();
            check("out_data", longint'($signed(dout)), longint'($signed(mon_e[OW-1:0])));
            check("out_chan", longint'(chan), longint'(mon_e[OW+1:OW]));
            check("out_ovf", longint'(ovf), longint'(mon_e[OW+2]));
         end
         held = dout;
         last_d[chan] = longint'($signed(dout));
         last_o[chan] = ovf;
         n_out++;
         if (!got_first) begin got_first = 1'b1; first_ch = int'(chan); end
      end else begin
         check("hold_data", longint'(dout), longint'(held));
         check("idle_ovf", longint'(ovf), 0);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic send(input int d, input bit v);
      din = IW'(d);
      nd  = v;
      if (v) model_accept(longint'(d));
      @(posedge clk); #1;
      nd = 1'b0;
   endtask

   task automatic idle(input int n);
      nd = 1'b0;
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic do_reset();
      nd = 1'b0; nd2 = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      model_reset();
      exp_q.delete();
      got_first = 1'b0;
      n_out = 0;
      for (int c = 0; c < NCH; c++) begin last_d[c] = 0; last_o[c] = 1'b0; end
   endtask

   task automatic send_frames(input int nf, input int a0, input int a1, input int a2, input int a3);
      for (int f = 0; f < nf; f++) begin
         send(a0, 1'b1); send(a1, 1'b1); send(a2, 1'b1); send(a3, 1'b1);
      end
   endtask

   typedef struct {
      int dcv [NCH];
      int sh;
      int ed  [NCH];
      bit eo  [NCH];
   } vec_t;

   function automatic vec_t mk(input int a0, a1, a2, a3, input int sh,
                               input int e0, e1, e2, e3, input bit o0, o1, o2, o3);
      vec_t v;
      v.dcv[0] = a0; v.dcv[1] = a1; v.dcv[2] = a2; v.dcv[3] = a3;
      v.sh = sh;
      v.ed[0] = e0; v.ed[1] = e1; v.ed[2] = e2; v.ed[3] = e3;
      v.eo[0] = o0; v.eo[1] = o1; v.eo[2] = o2; v.eo[3] = o3;
      return v;
   endfunction

   initial begin
      vec_t tbl [7];
      int rset [8];
      rset = '{0, 1, 2, 3, 4, 5, 8, 16};

      tbl[0] = mk(100, -100, 0, 1, 2,  15625, -15625, 0, 156,      0, 0, 0, 0);
      tbl[1] = mk(100, -100, 0, 1, 0,  32767, -32768, 0, 625,      1, 1, 0, 0);
      tbl[2] = mk(2047, 2047, 2047, 2047, 0, 32767, 32767, 32767, 32767, 1, 1, 1, 1);
      tbl[3] = mk(2047, 2047, 2047, 2047, 6, 19990, 19990, 19990, 19990, 0, 0, 0, 0);
      tbl[4] = mk(-2048, -2048, -2048, -2048, 0, -32768, -32768, -32768, -32768, 1, 1, 1, 1);
      tbl[5] = mk(-1, 1, 0, -1, 63,    -1, 0, 0, -1,                0, 0, 0, 0);
      tbl[6] = mk(8191, -8192, 3, -3, 10, 4999, -5000, 1, -2,       0, 0, 0, 0);

      // reset state
      decim = 7'd5; shift = '0;
      do_reset();
      check("rst_data", longint'(dout), 0);
      check("rst_valid", longint'(dvalid), 0);
      check("rst_chan", longint'(chan), 0);
      check("rst_ovf", longint'(ovf), 0);
      check("rst_data1", longint'(dout2), 0);
      check("rst_valid1", longint'(dvalid2), 0);

      // single-channel N=1 R=4 impulse response
      for (int i = 0; i < 16; i++) begin
         din2 = (i == 0) ? IW'(1) : '0;
         nd2  = 1'b1;
         @(posedge clk); #1;
         nd2  = 1'b0;
         check("imp_valid", longint'(dvalid2), (i % 4 == 3) ? 1 : 0);
         if (i % 4 == 3) begin
            check("imp_data", longint'($signed(dout2)), (i == 3) ? 1 : 0);
            check("imp_chan", longint'(chan2), 0);
         end
      end

      // DC vector table, R=5
      for (int v = 0; v < 7; v++) begin
         decim = 7'd5;
         shift = SW'(tbl[v].sh);
         do_reset();
         for (int f = 0; f < 40; f++)
            for (int c = 0; c < NCH; c++) send(tbl[v].dcv[c], 1'b1);
         idle(2);
         for (int c = 0; c < NCH; c++) begin
            check($sformatf("vec%0d_data_ch%0d", v, c), last_d[c], longint'(tbl[v].ed[c]));
            check($sformatf("vec%0d_ovf_ch%0d", v, c), longint'(last_o[c]), longint'(tbl[v].eo[c]));
         end
      end

      // decimation change 5 -> 3 while dc=2
      decim = 7'd5; shift = '0;
      do_reset();
      send_frames(2, 1, 1, 1, 1);
      decim = 7'd3;
      send_frames(2, 1, 1, 1, 1);
      idle(2);
      check("rchg_none_before_5", longint'(n_out), 0);
      send_frames(1, 1, 1, 1, 1);
      idle(2);
      check("rchg_after_5", longint'(n_out), 4);
      send_frames(2, 1, 1, 1, 1);
      idle(2);
      check("rchg_none_mid3", longint'(n_out), 4);
      send_frames(1, 1, 1, 1, 1);
      idle(2);
      check("rchg_after_8", longint'(n_out), 8);
      send_frames(27, 1, 1, 1, 1);
      idle(2);
      check("rchg_count", longint'(n_out), 44);
      for (int c = 0; c < NCH; c++) check("rchg_settle", last_d[c], 81);

      // reset mid-frame at ch=2, then a fresh run
      decim = 7'd5; shift = SW'(2);
      do_reset();
      send_frames(7, 100, 100, 100, 100);
      send(100, 1'b1); send(100, 1'b1);
      do_reset();
      send_frames(40, 100, -100, 0, 1);
      idle(2);
      check("mrst_first_chan", longint'(first_ch), 0);
      check("mrst_ch0", last_d[0], 15625);
      check("mrst_ch1", last_d[1], -15625);
      check("mrst_ch2", last_d[2], 0);
      check("mrst_ch3", last_d[3], 156);

      // randomized gapped traffic with runtime ratio/shift changes
      decim = DW'(rset[$urandom_range(0, 7)]);
      shift = SW'($urandom_range(0, 20));
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         if (i % 250 == 125) begin
            decim = DW'(rset[$urandom_range(0, 7)]);
            shift = SW'($urandom_range(0, 20));
         end
         if ($urandom_range(0, 1) == 1)
            send(int'($urandom_range(0, 16383)) - 8192, 1'b1);
         else
            send(int'($urandom_range(0, 16383)) - 8192, 1'b0);
      end
      idle(4);
      check("rand_outputs_seen", longint'(n_out > 0), 1);
      check("queue_empty", longint'(exp_q.size()), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
